// File: rtl/regfile.sv
// Banked ARM-style register file: 31 physical registers, CPSR and five SPSRs,
// with bank selection from the current CPSR mode, SPSR restore and exception entry.
module regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        read_en,
  input  logic [3:0]  read_reg,
  output logic [31:0] read_value,
  input  logic        write_en,
  input  logic [3:0]  write_reg,
  input  logic [31:0] write_value,
  input  logic        write_restore_from_SPSR,
  input  logic        mode_read_en,
  output logic [31:0] mode_read_value,
  input  logic        cpsr_read_en,
  output logic [31:0] cpsr_read_value,
  input  logic        cpsr_write_en,
  input  logic [31:0] cpsr_write_value,
  input  logic        exc_en,
  input  logic [2:0]  exc_mode,
  input  logic [31:0] exc_lr,
  output logic [31:0] pc
);

  localparam logic [2:0] MODE_USR = 3'd0;
  localparam logic [2:0] MODE_SYS = 3'd1;
  localparam logic [2:0] MODE_FIQ = 3'd2;
  localparam logic [2:0] MODE_IRQ = 3'd3;
  localparam logic [2:0] MODE_SVC = 3'd4;
  localparam logic [2:0] MODE_ABT = 3'd5;
  localparam logic [2:0] MODE_UND = 3'd6;

  localparam int          NUM_REGS  = 31;
  localparam int          NUM_SPSR  = 5;
  localparam logic [4:0]  PHYS_PC   = 5'd30;
  localparam logic [31:0] CPSR_RST  = 32'h0000_00D3;

  function automatic logic [2:0] mode_index(input logic [4:0] m);
    logic [2:0] idx;
    case (m)
      5'b10000: idx = MODE_USR;
      5'b11111: idx = MODE_SYS;
      5'b10001: idx = MODE_FIQ;
      5'b10010: idx = MODE_IRQ;
      5'b10011: idx = MODE_SVC;
      5'b10111: idx = MODE_ABT;
      5'b11011: idx = MODE_UND;
      default:  idx = MODE_USR;
    endcase
    return idx;
  endfunction

  function automatic logic [4:0] mode_encoding(input logic [2:0] idx);
    logic [4:0] m;
    case (idx)
      MODE_SYS: m = 5'b11111;
      MODE_FIQ: m = 5'b10001;
      MODE_IRQ: m = 5'b10010;
      MODE_SVC: m = 5'b10011;
      MODE_ABT: m = 5'b10111;
      MODE_UND: m = 5'b11011;
      default:  m = 5'b10000;
    endcase
    return m;
  endfunction

  // Physical layout: 0-7 R0-R7, 8-12 user R8-R12, 13-17 FIQ R8-R12,
  // 18-29 R13/R14 pairs for USR, FIQ, IRQ, SVC, ABT, UND, 30 R15.
  function automatic logic [4:0] phys_index(input logic [2:0] mode, input logic [3:0] r);
    logic [4:0] r5;
    logic [2:0] bank;
    logic [4:0] idx;
    r5   = {1'b0, r};
    bank = (mode == MODE_USR || mode == MODE_SYS) ? 3'd0 : mode - 3'd1;
    if (r == 4'd15)
      idx = PHYS_PC;
    else if (r <= 4'd7)
      idx = r5;
    else if (r <= 4'd12)
      idx = (mode == MODE_FIQ) ? 5'd13 + (r5 - 5'd8) : r5;
    else
      idx = 5'd18 + {1'b0, bank, 1'b0} + (r5 - 5'd13);
    return idx;
  endfunction

  logic [31:0] regs_reg  [0:NUM_REGS-1];
  logic [31:0] regs_next [0:NUM_REGS-1];
  logic [31:0] spsr_reg  [0:NUM_SPSR-1];
  logic [31:0] spsr_next [0:NUM_SPSR-1];
  logic [31:0] cpsr_reg;
  logic [31:0] cpsr_next;

  logic [2:0]  cur_mode;
  logic        cur_priv;
  logic        exc_valid;
  logic        restore_valid;
  logic [4:0]  wr_phys;
  logic [4:0]  rd_phys;
  logic [4:0]  exc_lr_phys;
  logic [31:0] cur_spsr;
  logic [31:0] exc_cpsr;

  logic [NUM_REGS-1:0] exc_hit;
  logic [NUM_REGS-1:0] wr_hit;
  logic [NUM_SPSR-1:0] spsr_hit;

  assign cur_mode      = mode_index(cpsr_reg[4:0]);
  assign cur_priv      = (cur_mode != MODE_USR);
  assign exc_valid     = exc_en && (exc_mode >= MODE_FIQ) && (exc_mode <= MODE_UND);
  assign restore_valid = write_en && write_restore_from_SPSR && (cur_mode >= MODE_FIQ);
  assign wr_phys       = phys_index(cur_mode, write_reg);
  assign rd_phys       = phys_index(cur_mode, read_reg);
  assign exc_lr_phys   = phys_index(exc_mode, 4'd14);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg_hit
      assign exc_hit[gi] = exc_valid && (exc_lr_phys == 5'(gi));
      assign wr_hit[gi]  = write_en && (wr_phys == 5'(gi));
    end
    for (gi = 0; gi < NUM_SPSR; gi++) begin : g_spsr_hit
      assign spsr_hit[gi] = exc_valid && (exc_mode == 3'(gi + 2));
    end
  endgenerate

  // Exception LR write outranks an ordinary write to the same physical register.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_next[i] = regs_reg[i];
      if (exc_hit[i])
        regs_next[i] = exc_lr;
      else if (wr_hit[i])
        regs_next[i] = write_value;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SPSR; i++)
      spsr_next[i] = spsr_hit[i] ? cpsr_reg : spsr_reg[i];
  end

  always_comb begin
    case (cur_mode)
      MODE_FIQ: cur_spsr = spsr_reg[0];
      MODE_IRQ: cur_spsr = spsr_reg[1];
      MODE_SVC: cur_spsr = spsr_reg[2];
      MODE_ABT: cur_spsr = spsr_reg[3];
      MODE_UND: cur_spsr = spsr_reg[4];
      default:  cur_spsr = cpsr_reg;
    endcase
  end

  always_comb begin
    exc_cpsr      = cpsr_reg;
    exc_cpsr[4:0] = mode_encoding(exc_mode);
    exc_cpsr[7]   = 1'b1;
    if (exc_mode == MODE_FIQ)
      exc_cpsr[6] = 1'b1;
  end

  always_comb begin
    cpsr_next = cpsr_reg;
    if (exc_valid)
      cpsr_next = exc_cpsr;
    else if (restore_valid)
      cpsr_next = cur_spsr;
    else if (cpsr_write_en)
      cpsr_next = cur_priv ? cpsr_write_value : {cpsr_write_value[31:28], cpsr_reg[27:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs_reg[i] <= '0;
      for (int i = 0; i < NUM_SPSR; i++)
        spsr_reg[i] <= '0;
      cpsr_reg <= CPSR_RST;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        regs_reg[i] <= regs_next[i];
      for (int i = 0; i < NUM_SPSR; i++)
        spsr_reg[i] <= spsr_next[i];
      cpsr_reg <= cpsr_next;
    end
  end

  // Reads return post-edge state, which gives same-edge write bypass for free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_value      <= '0;
      mode_read_value <= '0;
      cpsr_read_value <= '0;
    end else begin
      if (read_en)
        read_value <= regs_next[rd_phys];
      if (mode_read_en)
        mode_read_value <= {29'b0, mode_index(cpsr_next[4:0])};
      if (cpsr_read_en)
        cpsr_read_value <= cpsr_next;
    end
  end

  assign pc = regs_reg[PHYS_PC];

endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile: banking, CPSR writes, exception
// entry, SPSR restore, same-edge bypass/priority and reset.
module tb_regfile;
  logic        clk = 1'b0;
  logic        rst;
  logic        read_en;
  logic [3:0]  read_reg;
  logic [31:0] read_value;
  logic        write_en;
  logic [3:0]  write_reg;
  logic [31:0] write_value;
  logic        write_restore_from_SPSR;
  logic        mode_read_en;
  logic [31:0] mode_read_value;
  logic        cpsr_read_en;
  logic [31:0] cpsr_read_value;
  logic        cpsr_write_en;
  logic [31:0] cpsr_write_value;
  logic        exc_en;
  logic [2:0]  exc_mode;
  logic [31:0] exc_lr;
  logic [31:0] pc;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  regfile dut (
    .clk(clk), .rst(rst),
    .read_en(read_en), .read_reg(read_reg), .read_value(read_value),
    .write_en(write_en), .write_reg(write_reg), .write_value(write_value),
    .write_restore_from_SPSR(write_restore_from_SPSR),
    .mode_read_en(mode_read_en), .mode_read_value(mode_read_value),
    .cpsr_read_en(cpsr_read_en), .cpsr_read_value(cpsr_read_value),
    .cpsr_write_en(cpsr_write_en), .cpsr_write_value(cpsr_write_value),
    .exc_en(exc_en), .exc_mode(exc_mode), .exc_lr(exc_lr), .pc(pc)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
    $display("[TB] %s observed %h expected %h", tag, observed, expected);
  endtask

  task automatic idle();
    read_en = 0; read_reg = 0; write_en = 0; write_reg = 0; write_value = 0;
    write_restore_from_SPSR = 0; mode_read_en = 0; cpsr_read_en = 0;
    cpsr_write_en = 0; cpsr_write_value = 0; exc_en = 0; exc_mode = 0; exc_lr = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] r, input logic [31:0] v, input logic restore);
    write_en = 1; write_reg = r; write_value = v; write_restore_from_SPSR = restore;
    tick(); idle();
  endtask

  task automatic do_cpsr_write(input logic [31:0] v);
    cpsr_write_en = 1; cpsr_write_value = v;
    tick(); idle();
  endtask

  task automatic do_exc(input logic [2:0] m, input logic [31:0] lr);
    exc_en = 1; exc_mode = m; exc_lr = lr;
    tick(); idle();
  endtask

  // One edge reading a register, the mode and the CPSR together.
  task automatic do_reads(input logic [3:0] r);
    read_en = 1; read_reg = r; mode_read_en = 1; cpsr_read_en = 1;
    tick(); idle();
  endtask

  initial begin
    idle();
    rst = 1;
    tick(); tick();
    check("reset_read_value", read_value, 32'h0);
    check("reset_cpsr_read", cpsr_read_value, 32'h0);
    check("reset_mode_read", mode_read_value, 32'h0);
    check("reset_pc", pc, 32'h0);
    rst = 0;
    tick();

    do_reads(4'd0);
    check("init_cpsr", cpsr_read_value, 32'h0000_00D3);
    check("init_mode_svc", mode_read_value, 32'd4);
    check("init_r0", read_value, 32'h0);

    // SVC-banked R13, then drop to USR and see the user R13
    do_write(4'd13, 32'h1000, 0);
    do_reads(4'd13);
    check("svc_r13", read_value, 32'h1000);
    do_cpsr_write(32'h0000_0010);
    do_reads(4'd13);
    check("usr_r13_empty", read_value, 32'h0);
    check("usr_mode", mode_read_value, 32'd0);
    do_write(4'd13, 32'h2000, 0);
    do_cpsr_write(32'hA000_00D3);
    do_reads(4'd13);
    check("usr_cpsr_flags_only", cpsr_read_value, 32'hA000_0010);
    check("usr_mode_kept", mode_read_value, 32'd0);
    check("usr_r13", read_value, 32'h2000);

    // Back to SVC through an exception, then set the flags for the FIQ test
    do_exc(3'd4, 32'h55);
    do_reads(4'd14);
    check("exc_svc_cpsr", cpsr_read_value, 32'hA000_0093);
    check("exc_svc_lr", read_value, 32'h55);
    do_cpsr_write(32'h6000_00D3);
    do_reads(4'd13);
    check("svc_full_cpsr_write", cpsr_read_value, 32'h6000_00D3);
    check("svc_r13_retained", read_value, 32'h1000);

    // FIQ entry: flags kept, I and F set, FIQ-banked R14 and R8
    do_exc(3'd2, 32'h44);
    do_reads(4'd14);
    check("fiq_cpsr", cpsr_read_value, 32'h6000_00D1);
    check("fiq_mode", mode_read_value, 32'd2);
    check("fiq_r14", read_value, 32'h44);
    do_write(4'd8, 32'h88, 0);
    do_reads(4'd8);
    check("fiq_r8", read_value, 32'h88);

    // Return from FIQ: R15 write plus SPSR_fiq restore
    do_write(4'd15, 32'h80, 1);
    check("fiq_restore_pc", pc, 32'h80);
    do_reads(4'd8);
    check("fiq_restore_cpsr", cpsr_read_value, 32'h6000_00D3);
    check("fiq_restore_mode", mode_read_value, 32'd4);
    check("user_r8_distinct", read_value, 32'h0);
    do_reads(4'd14);
    check("svc_r14_retained", read_value, 32'h55);

    // Restore in USR writes R15 but leaves CPSR alone
    do_cpsr_write(32'h0000_0010);
    do_write(4'd15, 32'h100, 1);
    check("usr_restore_pc", pc, 32'h100);
    do_reads(4'd15);
    check("usr_restore_cpsr", cpsr_read_value, 32'h0000_0010);
    check("usr_r15_read", read_value, 32'h100);

    // Same-edge read/write bypass
    read_en = 1; read_reg = 4'd3; write_en = 1; write_reg = 4'd3; write_value = 32'hDEAD_BEEF;
    tick(); idle();
    check("bypass_r3", read_value, 32'hDEAD_BEEF);
    read_reg = 4'd0;
    tick();
    check("read_hold", read_value, 32'hDEAD_BEEF);

    // Exception beats a same-edge CPSR write; bypassed CPSR/mode reads
    exc_en = 1; exc_mode = 3'd3; exc_lr = 32'h77;
    cpsr_write_en = 1; cpsr_write_value = 32'hF000_00DF;
    cpsr_read_en = 1; mode_read_en = 1;
    tick(); idle();
    check("exc_over_cpsr_write", cpsr_read_value, 32'h0000_0092);
    check("exc_mode_bypass", mode_read_value, 32'd3);
    do_reads(4'd14);
    check("irq_r14", read_value, 32'h77);

    // Invalid exception mode has no effect
    do_exc(3'd7, 32'h99);
    do_reads(4'd14);
    check("invalid_exc_cpsr", cpsr_read_value, 32'h0000_0092);
    check("invalid_exc_r14", read_value, 32'h77);

    // Exception LR write beats a same-edge write to the same register
    exc_en = 1; exc_mode = 3'd3; exc_lr = 32'hAAAA;
    write_en = 1; write_reg = 4'd14; write_value = 32'hBBBB;
    read_en = 1; read_reg = 4'd14;
    tick(); idle();
    check("exc_lr_wins_bypass", read_value, 32'hAAAA);
    do_reads(4'd14);
    check("exc_lr_wins_stored", read_value, 32'hAAAA);

    // Reset in the middle of a write
    write_en = 1; write_reg = 4'd15; write_value = 32'h1234;
    rst = 1;
    tick();
    rst = 0; idle();
    check("midreset_pc", pc, 32'h0);
    do_reads(4'd3);
    check("midreset_cpsr", cpsr_read_value, 32'h0000_00D3);
    check("midreset_r3", read_value, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
